// File: rtl/stage_branch_pkg.sv
// Shared definitions for the stage/branch sequencer: BRDEC bit positions,
// divide-sequence state encoding and the small one-hot decode helper.
package stage_branch_pkg;

    // Bit positions inside BRDEC, named after the {BR1,BR2} pair they flag.
    localparam int BR_11 = 3;
    localparam int BR_10 = 2;
    localparam int BR_01 = 1;
    localparam int BR_00 = 0;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_e;

    // One-hot decode of a 2-bit value; with n = {BR1,BR2} the set bit lands
    // exactly on the BR_xx index named above.
    function automatic logic [3:0] onehot_decode(input logic [1:0] n);
        onehot_decode = 4'b0001 << n;
    endfunction

endpackage

// File: rtl/stage_branch_seq_div_step_ctr.sv
// Divide-sequence step counter: tracks whether a divide is running, which
// step it is on, and emits a one-cycle done pulse after the final step.
module div_step_ctr
    import stage_branch_pkg::*;
#(
    parameter int DIV_STEPS = 7,
    parameter int CW        = 3
) (
    input  logic          CLOCK,
    input  logic          rst_,
    input  logic          abort_i,    // restart clear, kills a divide silently
    input  logic          advance_i,  // end-of-MCT strobe
    input  logic          start_i,    // divide request, honoured only when idle
    output logic          act_o,
    output logic          last_o,     // running and on the final step
    output logic [CW-1:0] cnt_o,
    output logic          done_o
);

    localparam logic [CW-1:0] LAST_CNT = CW'(DIV_STEPS - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    // State register; reset and abort both clear without a done pulse.
    always_ff @(posedge CLOCK) begin
        if (!rst_ || abort_i) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: start from idle, step on each strobe, finish on the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (advance_i && start_i) begin
                    state_d = DIV_RUN;
                    cnt_d   = '0;
                end
            end
            DIV_RUN: begin
                if (advance_i) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = DIV_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign act_o  = (state_q == DIV_RUN);
    assign last_o = (state_q == DIV_RUN) && (cnt_q == LAST_CNT);
    assign cnt_o  = cnt_q;
    assign done_o = done_q;

endmodule

// File: rtl/stage_branch_seq.sv
// Stage/branch sequencer: instruction stage register with divide override,
// BR1/BR2 branch flip-flops, and the one-hot decodes consumed downstream.
module stage_branch_seq
    import stage_branch_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NSTG      = 2,
    parameter int DIV_STEPS = 7,
    parameter int DIV_STG   = 1
) (
    input  logic                         CLOCK,
    input  logic                         rst_,
    input  logic                         GOJAM,
    input  logic                         T12,
    input  logic                         STG_LD,
    input  logic [NSTG-1:0]              STG_NXT,
    input  logic                         DVST,
    input  logic                         TSGN,
    input  logic                         TMZ,
    input  logic                         TOV,
    input  logic [WIDTH-1:0]             WL,
    input  logic                         OVF_,
    input  logic                         UNF_,
    output logic [NSTG-1:0]              STG,
    output logic [(2**NSTG)-1:0]         ST_EQ,
    output logic                         BR1,
    output logic                         BR2,
    output logic [3:0]                   BRDEC,
    output logic                         DIV_ACT,
    output logic [$clog2(DIV_STEPS)-1:0] DIV_CNT,
    output logic                         DIV_DONE
);

    localparam int              CW        = $clog2(DIV_STEPS);
    localparam logic [NSTG-1:0] DIV_STG_V = NSTG'(DIV_STG);

    logic [NSTG-1:0] stg_q, stg_d;
    logic            br1_q, br1_d;
    logic            br2_q, br2_d;
    logic            div_act, div_last;

    div_step_ctr #(
        .DIV_STEPS (DIV_STEPS),
        .CW        (CW)
    ) u_div (
        .CLOCK     (CLOCK),
        .rst_      (rst_),
        .abort_i   (GOJAM),
        .advance_i (T12),
        .start_i   (DVST),
        .act_o     (div_act),
        .last_o    (div_last),
        .cnt_o     (DIV_CNT),
        .done_o    (DIV_DONE)
    );

    // Stage and branch registers; GOJAM clears exactly like reset.
    always_ff @(posedge CLOCK) begin
        if (!rst_ || GOJAM) begin
            stg_q <= '0;
            br1_q <= 1'b0;
            br2_q <= 1'b0;
        end else begin
            stg_q <= stg_d;
            br1_q <= br1_d;
            br2_q <= br2_d;
        end
    end

    // Stage mux: only moves on T12; an active divide owns the stage and
    // masks both STG_LD and DVST, and DVST wins over STG_LD when idle.
    always_comb begin
        stg_d = stg_q;
        if (T12) begin
            if (div_act) begin
                stg_d = div_last ? '0 : DIV_STG_V;
            end else if (DVST) begin
                stg_d = DIV_STG_V;
            end else if (STG_LD) begin
                stg_d = STG_NXT;
            end
        end
    end

    // Branch sources, any cycle: overflow test beats sign / minus-zero tests.
    always_comb begin
        br1_d = br1_q;
        br2_d = br2_q;
        if (TOV) begin
            br1_d = ~UNF_;
            br2_d = ~OVF_;
        end else begin
            if (TSGN) br1_d = WL[WIDTH-1];
            if (TMZ)  br2_d = &WL;
        end
    end

    for (genvar gi = 0; gi < 2**NSTG; gi++) begin : g_st_eq
        assign ST_EQ[gi] = (stg_q == NSTG'(gi));
    end

    assign STG     = stg_q;
    assign BR1     = br1_q;
    assign BR2     = br2_q;
    assign BRDEC   = onehot_decode({br1_q, br2_q});
    assign DIV_ACT = div_act;

endmodule

// File: tb/tb_stage_branch_seq.sv
// Bench for stage_branch_seq: two instances (default parameters and a
// wide/short-divide variant) driven by shared controls, compared every cycle
// against a behavioural model, plus directed checks of the key scenarios.
module tb_stage_branch_seq;

    logic        CLOCK = 1'b0;
    logic        rst_, GOJAM, T12, STG_LD, DVST, TSGN, TMZ, TOV, OVF_, UNF_;
    logic [1:0]  nxt_a;
    logic [2:0]  nxt_b;
    logic [15:0] wl_a;
    logic [31:0] wl_b;

    logic [1:0]  stg_a;   logic [3:0] st_eq_a; logic br1_a, br2_a; logic [3:0] brdec_a;
    logic        act_a;   logic [2:0] cnt_a;   logic done_a;
    logic [2:0]  stg_b;   logic [7:0] st_eq_b; logic br1_b, br2_b; logic [3:0] brdec_b;
    logic        act_b;   logic [0:0] cnt_b;   logic done_b;

    int total = 0;
    int bad   = 0;

    // Model state: stage, branch bits, T12 edges left in a divide, done pulse.
    int m_stg[2];
    int m_left[2];
    bit m_br1[2], m_br2[2], m_done[2];
    int steps[2] = '{7, 2};
    int dstg[2]  = '{1, 5};

    always #5 CLOCK = ~CLOCK;

    stage_branch_seq u_a (
        .CLOCK(CLOCK), .rst_(rst_), .GOJAM(GOJAM), .T12(T12), .STG_LD(STG_LD),
        .STG_NXT(nxt_a), .DVST(DVST), .TSGN(TSGN), .TMZ(TMZ), .TOV(TOV), .WL(wl_a),
        .OVF_(OVF_), .UNF_(UNF_), .STG(stg_a), .ST_EQ(st_eq_a), .BR1(br1_a), .BR2(br2_a),
        .BRDEC(brdec_a), .DIV_ACT(act_a), .DIV_CNT(cnt_a), .DIV_DONE(done_a)
    );

    stage_branch_seq #(.WIDTH(32), .NSTG(3), .DIV_STEPS(2), .DIV_STG(5)) u_b (
        .CLOCK(CLOCK), .rst_(rst_), .GOJAM(GOJAM), .T12(T12), .STG_LD(STG_LD),
        .STG_NXT(nxt_b), .DVST(DVST), .TSGN(TSGN), .TMZ(TMZ), .TOV(TOV), .WL(wl_b),
        .OVF_(OVF_), .UNF_(UNF_), .STG(stg_b), .ST_EQ(st_eq_b), .BR1(br1_b), .BR2(br2_b),
        .BRDEC(brdec_b), .DIV_ACT(act_b), .DIV_CNT(cnt_b), .DIV_DONE(done_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        bit sgn, ones;
        int nxt;
        for (int i = 0; i < 2; i++) begin
            sgn  = (i == 0) ? wl_a[15] : wl_b[31];
            ones = (i == 0) ? (wl_a == 16'hFFFF) : (wl_b == 32'hFFFF_FFFF);
            nxt  = (i == 0) ? int'(nxt_a) : int'(nxt_b);
            if (!rst_ || GOJAM) begin
                m_stg[i] = 0; m_left[i] = 0; m_br1[i] = 0; m_br2[i] = 0; m_done[i] = 0;
            end else begin
                m_done[i] = 0;
                if (T12) begin
                    if (m_left[i] > 0) begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_stg[i]  = 0;
                            m_done[i] = 1;
                        end
                    end else if (DVST) begin
                        m_left[i] = steps[i];
                        m_stg[i]  = dstg[i];
                    end else if (STG_LD) begin
                        m_stg[i] = nxt;
                    end
                end
                if (TOV) begin
                    m_br1[i] = !UNF_;
                    m_br2[i] = !OVF_;
                end else begin
                    if (TSGN) m_br1[i] = sgn;
                    if (TMZ)  m_br2[i] = ones;
                end
            end
        end
    endtask

    task automatic check_inst(input string p, input int i, input logic [7:0] stg,
                              input logic [7:0] st_eq, input logic b1, input logic b2,
                              input logic [3:0] brdec, input logic act,
                              input logic [7:0] cnt, input logic done);
        logic [7:0] e_eq;
        logic [3:0] e_dec;
        bit         e_act;
        e_eq  = 8'd1 << m_stg[i];
        e_dec = {m_br1[i] & m_br2[i], m_br1[i] & !m_br2[i],
                 !m_br1[i] & m_br2[i], !m_br1[i] & !m_br2[i]};
        e_act = (m_left[i] > 0);
        check({p, ".STG"},   64'(stg),   64'(m_stg[i]));
        check({p, ".ST_EQ"}, 64'(st_eq), 64'(e_eq));
        check({p, ".BR1"},   64'(b1),    64'(m_br1[i]));
        check({p, ".BR2"},   64'(b2),    64'(m_br2[i]));
        check({p, ".BRDEC"}, 64'(brdec), 64'(e_dec));
        check({p, ".ACT"},   64'(act),   64'(e_act));
        check({p, ".CNT"},   64'(cnt),   e_act ? 64'(steps[i] - m_left[i]) : 64'd0);
        check({p, ".DONE"},  64'(done),  64'(m_done[i]));
    endtask

    // One clock: model follows the edge, outputs are compared 1ns later.
    task automatic step();
        @(posedge CLOCK);
        model_update();
        #1;
        check_inst("A", 0, 8'(stg_a), 8'(st_eq_a), br1_a, br2_a, brdec_a, act_a, 8'(cnt_a), done_a);
        check_inst("B", 1, 8'(stg_b), st_eq_b, br1_b, br2_b, brdec_b, act_b, 8'(cnt_b), done_b);
    endtask

    task automatic idle_inputs();
        GOJAM = 0; T12 = 0; STG_LD = 0; DVST = 0; TSGN = 0; TMZ = 0; TOV = 0;
        OVF_ = 1; UNF_ = 1;
    endtask

    initial begin
        rst_ = 0; idle_inputs();
        nxt_a = 0; nxt_b = 0; wl_a = 0; wl_b = 0;
        for (int i = 0; i < 2; i++) begin
            m_stg[i] = 0; m_left[i] = 0; m_br1[i] = 0; m_br2[i] = 0; m_done[i] = 0;
        end

        // 1: reset then idle
        step(); step();
        rst_ = 1;
        for (int k = 0; k < 20; k++) step();
        check("t1.stg", 64'(stg_a), 0);
        check("t1.st_eq", 64'(st_eq_a), 64'h1);
        check("t1.brdec", 64'(brdec_a), 64'h1);
        check("t1.act", 64'(act_a), 0);

        // 2: STG_LD needs T12
        STG_LD = 1; nxt_a = 2; nxt_b = 2;
        step();
        check("t2.hold", 64'(stg_a), 0);
        T12 = 1; step(); idle_inputs();
        check("t2.stg", 64'(stg_a), 2);
        check("t2.st_eq", 64'(st_eq_a), 64'b0100);
        step();

        // 3: divide sequence on both instances; STG_LD mid-divide ignored
        DVST = 1; T12 = 1; STG_LD = 1; nxt_a = 3; step(); idle_inputs();
        check("t3.stg", 64'(stg_a), 1);
        check("t3.act", 64'(act_a), 1);
        check("t3b.stg", 64'(stg_b), 5);
        check("t3b.act", 64'(act_b), 1);
        for (int k = 1; k <= 7; k++) begin
            step();
            T12 = 1; STG_LD = 1; step(); idle_inputs();
            if (k < 7) begin
                check("t3.cnt", 64'(cnt_a), 64'(k));
                check("t3.stg_div", 64'(stg_a), 1);
                check("t3.nodone", 64'(done_a), 0);
            end else begin
                check("t3.done", 64'(done_a), 1);
                check("t3.stg_end", 64'(stg_a), 0);
                check("t3.act_end", 64'(act_a), 0);
            end
            if (k == 1) check("t3b.cnt", 64'(cnt_b), 1);
            if (k == 2) check("t3b.done", 64'(done_b), 1);
        end
        step();
        check("t3.done_pulse", 64'(done_a), 0);

        // 4: sign and minus-zero tests
        TSGN = 1; wl_a = 16'h8000; wl_b = 32'h8000_0000; step(); idle_inputs();
        check("t4.sgn", 64'(br1_a), 1);
        TSGN = 1; TMZ = 1; wl_a = 16'hFFFF; wl_b = 32'hFFFF_FFFF; step(); idle_inputs();
        check("t4.mz_br1", 64'(br1_a), 1);
        check("t4.mz_br2", 64'(br2_a), 1);
        check("t4.brdec", 64'(brdec_a), 64'b1000);
        TMZ = 1; wl_a = 16'h0001; wl_b = 32'h1; step(); idle_inputs();
        check("t4.nz", 64'(br2_a), 0);

        // 5: TOV beats TSGN
        TOV = 1; TSGN = 1; wl_a = 16'h8000; OVF_ = 0; UNF_ = 1; step(); idle_inputs();
        check("t5.br1", 64'(br1_a), 0);
        check("t5.br2", 64'(br2_a), 1);

        // 6: GOJAM then rst_ aborting a divide at count 3
        for (int r = 0; r < 2; r++) begin
            DVST = 1; T12 = 1; step(); idle_inputs();
            for (int k = 0; k < 3; k++) begin T12 = 1; step(); idle_inputs(); end
            check("t6.cnt3", 64'(cnt_a), 3);
            if (r == 0) GOJAM = 1; else rst_ = 0;
            step(); idle_inputs(); rst_ = 1;
            check("t6.act", 64'(act_a), 0);
            check("t6.cnt", 64'(cnt_a), 0);
            check("t6.stg", 64'(stg_a), 0);
            check("t6.br1", 64'(br1_a), 0);
            step();
            check("t6.nodone", 64'(done_a), 0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_   = ($urandom_range(0, 63) != 0);
            GOJAM  = ($urandom_range(0, 63) == 0);
            T12    = ($urandom_range(0, 3) == 0);
            STG_LD = 1'($urandom_range(0, 1));
            DVST   = ($urandom_range(0, 5) == 0);
            TSGN   = 1'($urandom_range(0, 1));
            TMZ    = 1'($urandom_range(0, 1));
            TOV    = ($urandom_range(0, 3) == 0);
            OVF_   = 1'($urandom_range(0, 1));
            UNF_   = 1'($urandom_range(0, 1));
            nxt_a  = 2'($urandom_range(0, 3));
            nxt_b  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       begin wl_a = 16'hFFFF; wl_b = 32'hFFFF_FFFF; end
                1:       begin wl_a = 16'h8000; wl_b = 32'h8000_0000; end
                default: begin wl_a = 16'($urandom); wl_b = $urandom; end
            endcase
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
